// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn scheduler: FSM state codes,
// PS/2 scan codes, damage/heal amounts and saturating HP arithmetic helpers.
package battle_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_INIT    = 3'd1;
  localparam state_t S_P_WAIT  = 3'd2;
  localparam state_t S_E_CHECK = 3'd3;
  localparam state_t S_E_WAIT  = 3'd4;
  localparam state_t S_P_CHECK = 3'd5;
  localparam state_t S_WIN     = 3'd6;
  localparam state_t S_LOSE    = 3'd7;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_HIT1 = 3'd1,
    ACT_HIT2 = 3'd2,
    ACT_HIT3 = 3'd3,
    ACT_HEAL = 3'd4
  } act_e;

  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;

  localparam logic [7:0] DMG_1 = 8'd8;
  localparam logic [7:0] DMG_2 = 8'd12;
  localparam logic [7:0] DMG_3 = 8'd20;

  localparam logic [7:0] HEAL_AMT   = 8'd10;
  localparam logic [1:0] HEAL_LIMIT = 2'd3;

  // a - b clamped at zero; both operands are full width so nothing wraps
  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] sat_add_cap8(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] cap);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, cap}) ? cap : sum[7:0];
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_if.sv
// Bundle of the battle controller's collision/keyboard inputs and HUD outputs.
// master drives the inputs (game logic / bench), slave is the controller.
interface battle_turn_ctrl_if;
  logic       col_e;
  logic       boss;
  logic [7:0] key_in;
  logic       key_valid;
  logic [6:0] HP_player;
  logic [7:0] HP_enemy;
  logic [2:0] p_attack;
  logic [2:0] e_attack;
  logic       in_battle;
  logic       win;
  logic       lose;

  modport master (
    output col_e, boss, key_in, key_valid,
    input  HP_player, HP_enemy, p_attack, e_attack, in_battle, win, lose
  );

  modport slave (
    input  col_e, boss, key_in, key_valid,
    output HP_player, HP_enemy, p_attack, e_attack, in_battle, win, lose
  );
endinterface

// File: rtl/battle_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting every cycle.
module battle_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_b,
  input  logic       rst,
  output logic [7:0] o_lfsr
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battle turn scheduler: alternates keyboard-driven player turns and LFSR-driven
// enemy turns, owns both HP registers. Optional heal move under BATTLE_HEAL_EN.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int         P_HP_MAX  = 100,
  parameter int         E_HP_NORM = 100,
  parameter int         E_HP_BOSS = 200,
  parameter int         E_DELAY   = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk_b,
  input  logic               rst,
  battle_turn_ctrl_if.slave  bus
);

  localparam int CW = (E_DELAY > 1) ? $clog2(E_DELAY) : 1;

  state_t        r_state, w_state_nxt;
  logic          r_col_prev;
  logic [6:0]    r_hp_p, w_hp_p_nxt;
  logic [7:0]    r_hp_e, w_hp_e_nxt;
  logic [2:0]    r_pa, w_pa_nxt;
  logic [2:0]    r_ea, w_ea_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_boss, w_boss_nxt;
  logic          r_in_battle, r_win, r_lose;
`ifdef BATTLE_HEAL_EN
  logic [1:0]    r_heal_cnt, w_heal_nxt;
  logic [7:0]    w_heal_sum;
`endif

  logic [7:0]    w_lfsr;
  logic          w_col_rise;
  logic [2:0]    w_e_str;
  logic [7:0]    w_e_dmg;
  logic [7:0]    w_p_sub;
  logic          w_unused;

  battle_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_b  (clk_b),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_col_rise = bus.col_e & ~r_col_prev;
  assign w_e_str    = {1'b0, w_lfsr[1:0]} + 3'd1;
  assign w_e_dmg    = r_boss ? {2'b00, w_e_str, 3'b000} : {3'b000, w_e_str, 2'b00};
  assign w_p_sub    = sat_sub8({1'b0, r_hp_p}, w_e_dmg);
`ifdef BATTLE_HEAL_EN
  assign w_heal_sum = sat_add_cap8({1'b0, r_hp_p}, HEAL_AMT, 8'(P_HP_MAX));
  assign w_unused   = ^{w_lfsr[7:2], w_p_sub[7], w_heal_sum[7]};
`else
  assign w_unused   = ^{w_lfsr[7:2], w_p_sub[7]};
`endif

  // Next-state and datapath update for the turn FSM
  always_comb begin
    w_state_nxt = r_state;
    w_hp_p_nxt  = r_hp_p;
    w_hp_e_nxt  = r_hp_e;
    w_pa_nxt    = r_pa;
    w_ea_nxt    = r_ea;
    w_cnt_nxt   = r_cnt;
    w_boss_nxt  = r_boss;
`ifdef BATTLE_HEAL_EN
    w_heal_nxt  = r_heal_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_col_rise) w_state_nxt = S_INIT;
        else            w_state_nxt = S_IDLE;
      end
      S_INIT: begin
        w_hp_p_nxt  = 7'(P_HP_MAX);
        w_hp_e_nxt  = bus.boss ? 8'(E_HP_BOSS) : 8'(E_HP_NORM);
        w_boss_nxt  = bus.boss;
        w_pa_nxt    = ACT_NONE;
        w_ea_nxt    = ACT_NONE;
`ifdef BATTLE_HEAL_EN
        w_heal_nxt  = 2'd0;
`endif
        w_state_nxt = S_P_WAIT;
      end
      S_P_WAIT: begin
        if (bus.key_valid) begin
          case (bus.key_in)
            KEY_1: begin
              w_pa_nxt    = ACT_HIT1;
              w_hp_e_nxt  = sat_sub8(r_hp_e, DMG_1);
              w_state_nxt = S_E_CHECK;
            end
            KEY_2: begin
              w_pa_nxt    = ACT_HIT2;
              w_hp_e_nxt  = sat_sub8(r_hp_e, DMG_2);
              w_state_nxt = S_E_CHECK;
            end
            KEY_3: begin
              w_pa_nxt    = ACT_HIT3;
              w_hp_e_nxt  = sat_sub8(r_hp_e, DMG_3);
              w_state_nxt = S_E_CHECK;
            end
`ifdef BATTLE_HEAL_EN
            KEY_4: begin
              if (r_heal_cnt != HEAL_LIMIT) begin
                w_pa_nxt    = ACT_HEAL;
                w_hp_p_nxt  = w_heal_sum[6:0];
                w_heal_nxt  = r_heal_cnt + 2'd1;
                w_state_nxt = S_E_CHECK;
              end else begin
                w_state_nxt = S_P_WAIT;
              end
            end
`endif
            default: w_state_nxt = S_P_WAIT;
          endcase
        end else begin
          w_state_nxt = S_P_WAIT;
        end
      end
      S_E_CHECK: begin
        if (r_hp_e == 8'd0) begin
          w_state_nxt = S_WIN;
        end else begin
          w_cnt_nxt   = CW'(E_DELAY - 1);
          w_state_nxt = S_E_WAIT;
        end
      end
      S_E_WAIT: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_ea_nxt    = w_e_str;
          w_hp_p_nxt  = w_p_sub[6:0];
          w_state_nxt = S_P_CHECK;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_P_CHECK: begin
        if (r_hp_p == 7'd0) w_state_nxt = S_LOSE;
        else                w_state_nxt = S_P_WAIT;
      end
      S_WIN, S_LOSE: begin
        if (!bus.col_e) w_state_nxt = S_IDLE;
        else            w_state_nxt = r_state;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State/datapath registers; status flags registered from the next state.
  // Reset samples col_e so a collision held through reset cannot start a battle.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col_prev  <= bus.col_e;
      r_hp_p      <= 7'(P_HP_MAX);
      r_hp_e      <= 8'd0;
      r_pa        <= 3'd0;
      r_ea        <= 3'd0;
      r_cnt       <= {CW{1'b0}};
      r_boss      <= 1'b0;
      r_in_battle <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
`ifdef BATTLE_HEAL_EN
      r_heal_cnt  <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_col_prev  <= bus.col_e;
      r_hp_p      <= w_hp_p_nxt;
      r_hp_e      <= w_hp_e_nxt;
      r_pa        <= w_pa_nxt;
      r_ea        <= w_ea_nxt;
      r_cnt       <= w_cnt_nxt;
      r_boss      <= w_boss_nxt;
      r_in_battle <= (w_state_nxt != S_IDLE);
      r_win       <= (w_state_nxt == S_WIN);
      r_lose      <= (w_state_nxt == S_LOSE);
`ifdef BATTLE_HEAL_EN
      r_heal_cnt  <= w_heal_nxt;
`endif
    end
  end

  assign bus.HP_player = r_hp_p;
  assign bus.HP_enemy  = r_hp_e;
  assign bus.p_attack  = r_pa;
  assign bus.e_attack  = r_ea;
  assign bus.in_battle = r_in_battle;
  assign bus.win       = r_win;
  assign bus.lose      = r_lose;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Scoreboard bench for battle_turn_ctrl: stimulus pushes cycle-tagged expected
// output snapshots; a negedge monitor pops and compares them.
module tb_battle_turn_ctrl;

  localparam int E_DELAY = 16;

  typedef struct {
    int         tag;
    string      name;
    logic [6:0] hp_p;
    logic [7:0] hp_e;
    logic [2:0] pa;
    logic [2:0] ea;
    logic       inb;
    logic       win;
    logic       lose;
  } exp_t;

  logic clk_b = 1'b0;
  logic rst   = 1'b1;
  battle_turn_ctrl_if bus ();

  battle_turn_ctrl #(
    .P_HP_MAX(100), .E_HP_NORM(100), .E_HP_BOSS(200),
    .E_DELAY(E_DELAY), .LFSR_SEED(8'hA5)
  ) dut (
    .clk_b (clk_b),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_b = ~clk_b;

  exp_t       exp_q[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] tb_lfsr  = 8'hA5;

  int m_hp_p, m_hp_e, m_pa, m_ea, m_heal;
  bit m_boss, m_inb, m_win, m_lose;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk_b) begin
    cyc     <= cyc + 1;
    tb_lfsr <= rst ? 8'hA5 : lfsr_step(tb_lfsr);
  end

  always @(negedge clk_b) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (e.tag != cyc) begin
        $display("FAIL %s: snapshot due at cycle %0d not compared until cycle %0d", e.name, e.tag, cyc);
      end else if (bus.HP_player !== e.hp_p || bus.HP_enemy !== e.hp_e || bus.p_attack !== e.pa ||
                   bus.e_attack !== e.ea || bus.in_battle !== e.inb || bus.win !== e.win ||
                   bus.lose !== e.lose) begin
        $display("FAIL %s @%0d: got hp_p=%0d hp_e=%0d pa=%0d ea=%0d ib=%0b w=%0b l=%0b, want hp_p=%0d hp_e=%0d pa=%0d ea=%0d ib=%0b w=%0b l=%0b",
                 e.name, cyc, bus.HP_player, bus.HP_enemy, bus.p_attack, bus.e_attack,
                 bus.in_battle, bus.win, bus.lose, e.hp_p, e.hp_e, e.pa, e.ea, e.inb, e.win, e.lose);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic push(input int tag, input string nm);
    exp_t e;
    e.tag  = tag;  e.name = nm;
    e.hp_p = 7'(m_hp_p); e.hp_e = 8'(m_hp_e);
    e.pa   = 3'(m_pa);   e.ea   = 3'(m_ea);
    e.inb  = m_inb; e.win = m_win; e.lose = m_lose;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_b);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    m_hp_p = 100; m_hp_e = 0; m_pa = 0; m_ea = 0; m_heal = 0;
    m_boss = 1'b0; m_inb = 1'b0; m_win = 1'b0; m_lose = 1'b0;
    push(cyc + 1, nm);
    @(negedge clk_b);
    rst = 1'b0;
  endtask

  task automatic start_battle(input bit b, input string nm);
    int n;
    n = cyc + 1;
    bus.boss  = b;
    bus.col_e = 1'b1;
    m_inb = 1'b1; m_win = 1'b0; m_lose = 1'b0;
    push(n, {nm, "_init"});
    m_hp_p = 100; m_hp_e = b ? 200 : 100; m_pa = 0; m_ea = 0; m_heal = 0; m_boss = b;
    push(n + 1, {nm, "_load"});
    wait_until(n + 1);
  endtask

  task automatic end_battle(input string nm);
    bus.col_e = 1'b0;
    m_inb = 1'b0; m_win = 1'b0; m_lose = 1'b0;
    push(cyc + 1, nm);
    @(negedge clk_b);
  endtask

  task automatic press(input logic [7:0] code, input string nm, output int k, output bit acc);
    k   = cyc + 1;
    acc = 1'b0;
    case (code)
      8'h16: begin m_pa = 1; m_hp_e = (m_hp_e > 8)  ? m_hp_e - 8  : 0; acc = 1'b1; end
      8'h1E: begin m_pa = 2; m_hp_e = (m_hp_e > 12) ? m_hp_e - 12 : 0; acc = 1'b1; end
      8'h26: begin m_pa = 3; m_hp_e = (m_hp_e > 20) ? m_hp_e - 20 : 0; acc = 1'b1; end
`ifdef BATTLE_HEAL_EN
      8'h25: begin
        if (m_heal < 3) begin
          m_pa = 4; m_hp_p = (m_hp_p + 10 > 100) ? 100 : m_hp_p + 10; m_heal++; acc = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    push(k, nm);
    bus.key_in    = code;
    bus.key_valid = 1'b1;
    @(negedge clk_b);
    bus.key_valid = 1'b0;
  endtask

  // Enemy turn following a key accepted at edge k (called at the negedge after k)
  task automatic enemy_turn(input int k, input bit inj, input bit pk);
    int h, dmg;
    logic [7:0] v;
    if (m_hp_e == 0) begin
      m_win = 1'b1;
      push(k + 1, "win");
      wait_until(k + 1);
      return;
    end
    h = k + 1 + E_DELAY;
    v = tb_lfsr;
    repeat (E_DELAY) v = lfsr_step(v);
    push(h - 1, "pre_hit");
    m_ea   = int'(v[1:0]) + 1;
    dmg    = m_boss ? 8 * m_ea : 4 * m_ea;
    m_hp_p = (m_hp_p > dmg) ? m_hp_p - dmg : 0;
    push(h, "enemy_hit");
    if (m_hp_p == 0) begin
      m_lose = 1'b1;
      push(h + 1, "lose");
    end else begin
      push(h + 1, pk ? "key_at_pcheck" : "p_check");
    end
    if (inj) begin
      wait_until(k + 5);
      bus.key_in = 8'h1E; bus.key_valid = 1'b1;
      @(negedge clk_b);
      bus.key_valid = 1'b0;
    end
    if (pk && !m_lose) begin
      wait_until(h);
      bus.key_in = 8'h26; bus.key_valid = 1'b1;
      @(negedge clk_b);
      bus.key_valid = 1'b0;
    end
    wait_until(h + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d pending snapshots", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int k, guard;
    bit acc;
    bus.col_e = 1'b0; bus.boss = 1'b0; bus.key_in = 8'h00; bus.key_valid = 1'b0;
    @(negedge clk_b);
    do_reset("reset");
    repeat (2) @(negedge clk_b);

    // Normal enemy: ignored codes, then five '3' presses down to a win
    start_battle(1'b0, "norm");
    press(8'h1C, "bad_key", k, acc);
    press(8'h25, "key4", k, acc);
    if (acc) enemy_turn(k, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      press(8'h26, "key3", k, acc);
      enemy_turn(k, i == 0, i == 1);
    end
    end_battle("win_idle");

    // Boss: '1' each turn until the player dies
    start_battle(1'b1, "boss");
    guard = 0;
    while (!m_lose && guard < 40) begin
      press(8'h16, "key1", k, acc);
      enemy_turn(k, 1'b0, 1'b0);
      guard++;
    end
    end_battle("lose_idle");

    // Reset during E_WAIT, held collision, then restart
    start_battle(1'b0, "rb");
    press(8'h1E, "key2", k, acc);
    wait_until(k + 5);
    do_reset("reset_mid");
    repeat (4) @(negedge clk_b);
    push(cyc + 1, "held_col");
    @(negedge clk_b);
    bus.col_e = 1'b0;
    repeat (2) @(negedge clk_b);
    start_battle(1'b0, "restart");

`ifdef BATTLE_HEAL_EN
    for (int i = 0; i < 4; i++) begin
      press(8'h16, "key1", k, acc);
      enemy_turn(k, 1'b0, 1'b0);
      press(8'h25, "heal", k, acc);
      if (acc) enemy_turn(k, 1'b0, 1'b0);
    end
`else
    press(8'h16, "key1", k, acc);
    enemy_turn(k, 1'b0, 1'b0);
    press(8'h25, "key4_off", k, acc);
`endif

    repeat (3) @(negedge clk_b);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d snapshots never compared, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
